// File: rtl/ascii_save_capture.sv
// ascii_save_capture
// ------------------
// Captures the byte stream the emulated ACIA transmits (BASIC SAVE/LIST)
// into an on-chip buffer. When the stream has been quiet for IDLE_CYCLES
// clocks, an HPS upload is requested and the buffer is served over the
// ioctl upload read port so the host can write it out as a text file.
//
// Ports:
//   clk              system clock (clk_sys)
//   n_reset          synchronous active-low reset
//   enable           capture armed; tx_strobe ignored when low
//   tx_strobe        one-cycle pulse on ACIA transmit-register write
//   tx_data          byte written, valid with tx_strobe
//   clear            one-cycle pulse: discard buffer contents
//   ioctl_upload     HPS upload in progress (level)
//   ioctl_rd         one-cycle read request from hps_io
//   ioctl_addr       byte address of the read
//   ioctl_din        read data, valid the cycle after ioctl_rd
//   ioctl_upload_req request for the HPS to start an upload
//   captured_len     number of bytes held (saturates at 2^ADDR_W)
//   overflow         sticky: at least one byte was lost
//   busy             high while capturing or uploading
module ascii_save_capture #(
  parameter int ADDR_W      = 14,
  parameter int IDLE_CYCLES = 48000000,
  parameter int DROP_NULLS  = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic              tx_strobe,
  input  logic [7:0]        tx_data,
  input  logic              clear,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [15:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic [ADDR_W:0]   captured_len,
  output logic              overflow,
  output logic              busy
);

  localparam int               CNT_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  LEN_ONE   = (ADDR_W + 1)'(1);
  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [7:0]       EOF_PAD   = 8'h1A;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_UPLOAD  = 2'd3
  } state_t;

  // Source of ioctl_din: nothing read yet, buffer RAM, or EOF padding.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_EOF  = 2'd2
  } din_sel_t;

  state_t            state_reg;
  logic [ADDR_W:0]   len_reg;
  logic              overflow_reg;
  logic              req_reg;
  logic              busy_reg;
  logic              upload_prev_reg;
  logic [CNT_W-1:0]  idle_cnt_reg;
  din_sel_t          din_sel_reg;

  logic [7:0]        mem [0:DEPTH-1];
  logic [7:0]        mem_rd_reg;

  logic              byte_kept;
  logic              strobe_seen;
  logic              accept;
  logic              buf_full;
  logic              mem_we;
  logic              upload_fall;
  logic              rd_in_range;
  logic [31:0]       addr_ext;
  logic [31:0]       len_ext;

  // A byte is worth keeping unless it is a padding null and nulls are dropped.
  assign byte_kept   = (DROP_NULLS == 0) ? 1'b1 : (tx_data != 8'h00);
  assign strobe_seen = tx_strobe & enable;
  assign accept      = strobe_seen & byte_kept &
                       ((state_reg == ST_EMPTY) || (state_reg == ST_CAPTURE));
  // len_reg only reaches 2^ADDR_W when every slot is used.
  assign buf_full    = len_reg[ADDR_W];
  // clear beats a same-cycle strobe; in EMPTY len_reg is 0 so this writes mem[0].
  assign mem_we      = n_reset & ~clear & accept & ~buf_full;
  assign upload_fall = upload_prev_reg & ~ioctl_upload;

  // Full-width compare so addresses past the buffer (upper bits set) pad
  // with EOF rather than aliasing back into the RAM.
  assign addr_ext    = {16'h0000, ioctl_addr};
  assign len_ext     = 32'(len_reg);
  assign rd_in_range = addr_ext < len_ext;

  // Buffer RAM: registered read, old data on a same-address write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_reg[ADDR_W-1:0]] <= tx_data;
    end
    if (ioctl_rd) begin
      mem_rd_reg <= mem[ioctl_addr[ADDR_W-1:0]];
    end
  end

  // The range decision is registered with the RAM read so ioctl_din holds
  // until the next read even if captured_len changes meanwhile.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      din_sel_reg <= SEL_ZERO;
    end else if (ioctl_rd) begin
      din_sel_reg <= rd_in_range ? SEL_MEM : SEL_EOF;
    end
  end

  always_comb begin
    ioctl_din = 8'h00;
    case (din_sel_reg)
      SEL_MEM: ioctl_din = mem_rd_reg;
      SEL_EOF: ioctl_din = EOF_PAD;
      default: ioctl_din = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      upload_prev_reg <= 1'b0;
    end else begin
      upload_prev_reg <= ioctl_upload;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg    <= ST_EMPTY;
      len_reg      <= '0;
      overflow_reg <= 1'b0;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (clear) begin
            len_reg      <= '0;
            overflow_reg <= 1'b0;
            req_reg      <= 1'b0;
          end else if (accept) begin
            // First byte of a new capture; a stale overflow from the
            // previous upload is forgotten here.
            len_reg      <= LEN_ONE;
            overflow_reg <= 1'b0;
            idle_cnt_reg <= '0;
            state_reg    <= ST_CAPTURE;
            busy_reg     <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          if (clear) begin
            state_reg    <= ST_EMPTY;
            busy_reg     <= 1'b0;
            len_reg      <= '0;
            overflow_reg <= 1'b0;
            req_reg      <= 1'b0;
            idle_cnt_reg <= '0;
          end else begin
            if (accept) begin
              if (!buf_full) begin
                len_reg <= len_reg + LEN_ONE;
              end else begin
                overflow_reg <= 1'b1;
              end
            end
            // Any strobe, kept or dropped, shows the stream is still alive.
            // enable is not consulted for the timeout itself, so disarming
            // mid-capture still leads to an upload.
            if (strobe_seen) begin
              idle_cnt_reg <= '0;
            end else if (idle_cnt_reg == IDLE_LAST) begin
              state_reg    <= ST_READY;
              req_reg      <= 1'b1;
              busy_reg     <= 1'b0;
              idle_cnt_reg <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + CNT_ONE;
            end
          end
        end

        ST_READY: begin
          if (clear) begin
            state_reg    <= ST_EMPTY;
            len_reg      <= '0;
            overflow_reg <= 1'b0;
            req_reg      <= 1'b0;
          end else if (ioctl_upload) begin
            state_reg <= ST_UPLOAD;
            req_reg   <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end

        ST_UPLOAD: begin
          // The buffer is frozen while the host reads it; a real byte
          // arriving now is lost.
          if (strobe_seen && byte_kept) begin
            overflow_reg <= 1'b1;
          end
          if (upload_fall) begin
            state_reg <= ST_EMPTY;
            busy_reg  <= 1'b0;
            len_reg   <= '0;
          end
        end

        default: begin
          state_reg    <= ST_EMPTY;
          busy_reg     <= 1'b0;
          req_reg      <= 1'b0;
          idle_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign ioctl_upload_req = req_reg;
  assign captured_len     = len_reg;
  assign overflow         = overflow_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_ascii_save_capture.sv
// Bench for ascii_save_capture with a 16-byte buffer and a 100-cycle idle
// timeout. Read data expectations are queued when a read is issued and
// checked when the read data becomes valid.
module tb_ascii_save_capture;

  localparam int ADDR_W = 4;
  localparam int IDLE   = 100;

  logic            clk = 1'b0;
  logic            n_reset;
  logic            enable;
  logic            tx_strobe;
  logic [7:0]      tx_data;
  logic            clear;
  logic            ioctl_upload;
  logic            ioctl_rd;
  logic [15:0]     ioctl_addr;
  logic [7:0]      ioctl_din;
  logic            ioctl_upload_req;
  logic [ADDR_W:0] captured_len;
  logic            overflow;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q [$];
  logic [15:0] addr_q [$];
  logic        rd_seen = 1'b0;

  ascii_save_capture #(
    .ADDR_W      (ADDR_W),
    .IDLE_CYCLES (IDLE),
    .DROP_NULLS  (1)
  ) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .enable           (enable),
    .tx_strobe        (tx_strobe),
    .tx_data          (tx_data),
    .clear            (clear),
    .ioctl_upload     (ioctl_upload),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_din        (ioctl_din),
    .ioctl_upload_req (ioctl_upload_req),
    .captured_len     (captured_len),
    .overflow         (overflow),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    tx_strobe = 1'b1;
    tx_data   = b;
    tick();
    tx_strobe = 1'b0;
    $display("strobe data=%02h len=%0d ovf=%0b", b, captured_len, overflow);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    ioctl_rd = 1'b0;
  endtask

  // Read data is valid after the edge that sampled ioctl_rd; check it on
  // the following falling edge.
  always @(posedge clk) rd_seen <= ioctl_rd;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("rd_pending", exp_q.size(), 1);
      end else begin
        logic [7:0]  e;
        logic [15:0] a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        $display("read addr=%04h data=%02h", a, ioctl_din);
        check("rd_data", {24'h0, ioctl_din}, {24'h0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int req_cnt;
    int waited;

    n_reset      = 1'b0;
    enable       = 1'b0;
    tx_strobe    = 1'b0;
    tx_data      = 8'h00;
    clear        = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 16'h0000;
    tick();
    tick();
    n_reset = 1'b1;

    // Reset state
    check("rst_len",  captured_len, 0);
    check("rst_ovf",  overflow, 0);
    check("rst_req",  ioctl_upload_req, 0);
    check("rst_din",  ioctl_din, 8'h00);
    check("rst_busy", busy, 0);

    // Basic capture with a dropped null, then idle timeout
    enable = 1'b1;
    strobe(8'h41);
    check("cap_busy", busy, 1);
    strobe(8'h42);
    strobe(8'h00);
    strobe(8'h43);
    req_cnt = 0;
    for (int i = 0; i < IDLE - 1; i++) begin
      tick();
      if (ioctl_upload_req) req_cnt++;
    end
    check("idle_no_early_req", req_cnt, 0);
    tick();
    check("idle_req", ioctl_upload_req, 1);
    check("cap_len", captured_len, 3);
    check("ready_busy", busy, 0);
    rd(16'd0, 8'h41);
    rd(16'd1, 8'h42);
    rd(16'd2, 8'h43);
    rd(16'd3, 8'h1A);
    rd(16'h0101, 8'h1A);

    // Upload handshake, strobe during upload, upload end
    ioctl_upload = 1'b1;
    tick();
    check("upl_req_drop", ioctl_upload_req, 0);
    check("upl_busy", busy, 1);
    strobe(8'h55);
    check("upl_ovf", overflow, 1);
    check("upl_len", captured_len, 3);
    rd(16'd3, 8'h1A);
    rd(16'd0, 8'h41);
    ioctl_upload = 1'b0;
    tick();
    check("upl_end_len", captured_len, 0);
    check("upl_end_busy", busy, 0);
    check("upl_end_ovf_kept", overflow, 1);
    rd(16'd0, 8'h1A);

    // Fill past capacity
    for (int i = 0; i < 20; i++) strobe(8'h61 + 8'(i));
    check("full_len", captured_len, 16);
    check("full_ovf", overflow, 1);
    rd(16'd15, 8'h70);
    rd(16'd16, 8'h1A);
    rd(16'd0, 8'h61);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_len", captured_len, 0);
    check("clr_ovf", overflow, 0);
    check("clr_busy", busy, 0);

    // Strobes spaced 90 cycles apart keep the timeout from firing
    req_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      strobe(8'h30 + 8'(b));
      if (b < 9) begin
        for (int i = 0; i < 89; i++) begin
          tick();
          if (ioctl_upload_req) req_cnt++;
        end
      end
    end
    for (int i = 0; i < IDLE - 1; i++) begin
      tick();
      if (ioctl_upload_req) req_cnt++;
    end
    check("spaced_no_early_req", req_cnt, 0);
    tick();
    check("spaced_req", ioctl_upload_req, 1);
    check("spaced_len", captured_len, 10);
    rd(16'd9, 8'h39);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ready_clr_req", ioctl_upload_req, 0);
    check("ready_clr_len", captured_len, 0);

    // clear and strobe together during capture
    for (int i = 0; i < 5; i++) strobe(8'h31 + 8'(i));
    check("pre_clr_len", captured_len, 5);
    tx_strobe = 1'b1;
    tx_data   = 8'h77;
    clear     = 1'b1;
    tick();
    tx_strobe = 1'b0;
    clear     = 1'b0;
    check("clrstb_len", captured_len, 0);
    check("clrstb_ovf", overflow, 0);
    check("clrstb_busy", busy, 0);
    req_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (ioctl_upload_req) req_cnt++;
    end
    check("clrstb_no_req", req_cnt, 0);

    // Reset in the middle of an upload
    for (int i = 0; i < 8; i++) strobe(8'h30 + 8'(i));
    waited = 0;
    while (!ioctl_upload_req && waited < 200) begin
      tick();
      waited++;
    end
    check("rst_upl_req", ioctl_upload_req, 1);
    ioctl_upload = 1'b1;
    tick();
    check("rst_upl_len", captured_len, 8);
    rd(16'd0, 8'h30);
    strobe(8'h55);
    check("rst_upl_ovf", overflow, 1);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    check("mid_rst_len",  captured_len, 0);
    check("mid_rst_ovf",  overflow, 0);
    check("mid_rst_req",  ioctl_upload_req, 0);
    check("mid_rst_din",  ioctl_din, 8'h00);
    check("mid_rst_busy", busy, 0);
    ioctl_upload = 1'b0;
    tick();
    strobe(8'h5A);
    check("post_rst_len", captured_len, 1);
    rd(16'd0, 8'h5A);
    tick();
    tick();
    check("rd_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
